// File: rtl/interrupt_controller.sv
// Game Boy interrupt controller: IF/IE/IME registers, prioritized dispatch
// handshake with the CPU, and the HALT wake line.
module interrupt_controller (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ADDR,
    input  logic        WR,
    input  logic        RD,
    input  logic [7:0]  MMIO_DATA_out,
    output logic [7:0]  MMIO_DATA_in,
    input  logic        IRQ_VBLANK,
    input  logic        IRQ_LCDC,
    input  logic        IRQ_TIMER,
    input  logic        IRQ_SERIAL,
    input  logic        IRQ_JOYPAD,
    input  logic        EI,
    input  logic        DI,
    input  logic        RETI,
    input  logic        INSTR_BOUNDARY,
    input  logic        INT_ACK,
    output logic        INT_REQ,
    output logic [15:0] INT_VECTOR,
    output logic        VECTOR_VALID,
    output logic        WAKE
);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] VECTOR = 1'b1;

    localparam logic [15:0] ADDR_IF = 16'hFF0F;
    localparam logic [15:0] ADDR_IE = 16'hFFFF;

    logic [4:0]  if_q, if_d;
    logic [7:0]  ie_q, ie_d;
    logic        ime_q, ime_d;
    logic        ei_armed_q, ei_armed_d;
    logic [0:0]  state_q, state_d;
    logic [15:0] vector_q, vector_d;

    logic [4:0] irq;
    logic [4:0] pend;
    logic [2:0] sel_idx;
    logic       ack;
    logic       unused_rd;

    // Reads are side-effect free, so RD carries no information here.
    assign unused_rd = RD;

    assign irq  = {IRQ_JOYPAD, IRQ_SERIAL, IRQ_TIMER, IRQ_LCDC, IRQ_VBLANK};
    assign pend = ie_q[4:0] & if_q;
    assign ack  = INT_ACK && (state_q == IDLE);

    // Scan high to low so the lowest pending bit is the one that sticks.
    always_comb begin
        sel_idx = 3'd0;
        for (int i = 4; i >= 0; i--) begin
            if (pend[i]) begin
                sel_idx = i[2:0];
            end
        end
    end

    always_comb begin
        unique case (ADDR)
            ADDR_IF: MMIO_DATA_in = {3'b111, if_q};
            ADDR_IE: MMIO_DATA_in = ie_q;
            default: MMIO_DATA_in = 8'hFF;
        endcase
    end

    always_comb begin
        if_d = if_q;
        if (WR && (ADDR == ADDR_IF)) begin
            if_d = MMIO_DATA_out[4:0];
        end
        if (ack && (pend != 5'd0)) begin
            if_d[sel_idx] = 1'b0;
        end
        if_d = if_d | irq;
    end

    always_comb begin
        ie_d = ie_q;
        if (WR && (ADDR == ADDR_IE)) begin
            ie_d = MMIO_DATA_out;
        end
    end

    // EI only arms; IME rises at the boundary after the EI instruction's own.
    // Later assignments take priority, so DI is applied last.
    always_comb begin
        ime_d      = ime_q;
        ei_armed_d = ei_armed_q;
        if (ei_armed_q && INSTR_BOUNDARY) begin
            ime_d      = 1'b1;
            ei_armed_d = 1'b0;
        end
        if (EI) begin
            ei_armed_d = 1'b1;
        end
        if (RETI) begin
            ime_d = 1'b1;
        end
        if (ack) begin
            ime_d      = 1'b0;
            ei_armed_d = 1'b0;
        end
        if (DI) begin
            ime_d      = 1'b0;
            ei_armed_d = 1'b0;
        end
    end

    always_comb begin
        state_d  = state_q;
        vector_d = vector_q;
        unique case (state_q)
            IDLE: begin
                if (INT_ACK) begin
                    state_d  = VECTOR;
                    vector_d = (pend != 5'd0) ? (16'h0040 + {10'd0, sel_idx, 3'b000}) : 16'h0000;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            if_q       <= 5'd0;
            ie_q       <= 8'd0;
            ime_q      <= 1'b0;
            ei_armed_q <= 1'b0;
            state_q    <= IDLE;
            vector_q   <= 16'h0000;
        end else begin
            if_q       <= if_d;
            ie_q       <= ie_d;
            ime_q      <= ime_d;
            ei_armed_q <= ei_armed_d;
            state_q    <= state_d;
            vector_q   <= vector_d;
        end
    end

    assign INT_REQ      = (state_q == IDLE) && ime_q && (pend != 5'd0);
    assign VECTOR_VALID = (state_q == VECTOR);
    assign INT_VECTOR   = vector_q;
    assign WAKE         = (pend != 5'd0);

endmodule
